// File: rtl/rx_gate_if.sv
// Control/status bundle between the register block and the rx_gate window generator.
// master drives the controls and reads status; slave is the window generator itself.
interface rx_gate_if #(
  parameter int CW = 16
) ();
  logic          enable;
  logic          sync_in;
  logic          rxstrobe;
  logic [CW-1:0] delay;
  logic [CW-1:0] width;
  logic          clear_status;
  logic          gate_enable;
  logic          window_start;
  logic          window_done;
  logic          busy;
  logic          sync_overrun;
  logic [15:0]   window_count;

  modport master (
    output enable, sync_in, rxstrobe, delay, width, clear_status,
    input  gate_enable, window_start, window_done, busy, sync_overrun, window_count
  );

  modport slave (
    input  enable, sync_in, rxstrobe, delay, width, clear_status,
    output gate_enable, window_start, window_done, busy, sync_overrun, window_count
  );
endinterface

// File: rtl/rx_gate.sv
// Receive-window generator: after each IPP sync edge, skips `delay` rxstrobes and then
// holds gate_enable high for exactly `width` rxstrobes; reports start/done/count/overrun.
module rx_gate #(
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 16
) (
  input logic     clk,
  input logic     reset,
  rx_gate_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DELAY, WINDOW} state_t;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_ff_p0;
  logic                   sync_prev_p1;
  logic                   sync_edge_p2;
  logic [CW-1:0]          dly_cnt;
  logic [CW-1:0]          win_cnt;
  logic                   gate_q;
  logic                   start_q;
  logic                   done_q;
  logic                   busy_q;
  logic                   overrun_q;
  logic [15:0]            count_q;

  // Sync path: metastability chain, then a registered rising-edge pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_ff_p0   <= '0;
      sync_prev_p1 <= 1'b0;
      sync_edge_p2 <= 1'b0;
    end else begin
      sync_ff_p0   <= {sync_ff_p0[SYNC_STAGES-2:0], bus.sync_in};
      sync_prev_p1 <= sync_ff_p0[SYNC_STAGES-1];
      sync_edge_p2 <= sync_ff_p0[SYNC_STAGES-1] & ~sync_prev_p1;
    end
  end

  // Window FSM: delay/width/enable are only sampled when a sync edge is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dly_cnt   <= '0;
      win_cnt   <= '0;
      gate_q    <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= 16'h0000;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (bus.clear_status) overrun_q <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_edge_p2 && bus.enable && (bus.width != '0)) begin
            dly_cnt <= bus.delay;
            win_cnt <= bus.width;
            busy_q  <= 1'b1;
            if (bus.delay != '0) begin
              state <= DELAY;
            end else begin
              state   <= WINDOW;
              gate_q  <= 1'b1;
              start_q <= 1'b1;
            end
          end
        end
        DELAY: begin
          // A set in the same cycle as clear_status overrides the clear above.
          if (sync_edge_p2) overrun_q <= 1'b1;
          if (bus.rxstrobe) begin
            dly_cnt <= dly_cnt - CNT_ONE;
            if (dly_cnt == CNT_ONE) begin
              state   <= WINDOW;
              gate_q  <= 1'b1;
              start_q <= 1'b1;
            end
          end
        end
        WINDOW: begin
          if (sync_edge_p2) overrun_q <= 1'b1;
          if (bus.rxstrobe) begin
            win_cnt <= win_cnt - CNT_ONE;
            if (win_cnt == CNT_ONE) begin
              state   <= IDLE;
              gate_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              count_q <= count_q + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gate_enable  = gate_q;
  assign bus.window_start = start_q;
  assign bus.window_done  = done_q;
  assign bus.busy         = busy_q;
  assign bus.sync_overrun = overrun_q;
  assign bus.window_count = count_q;

endmodule
